// File: rtl/line_sequencer.sv
// Segment-table sequencer: issues stored line segments one at a time to a
// downstream line drawer, optionally following each with an erase pass.
module line_sequencer #(
  parameter int COORD_W = 11,
  parameter int DEPTH   = 8,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [COORD_W-1:0] load_x0,
  input  logic [COORD_W-1:0] load_y0,
  input  logic [COORD_W-1:0] load_x1,
  input  logic [COORD_W-1:0] load_y1,
  input  logic [CNT_W-1:0]   num_lines,
  input  logic               erase_en,
  input  logic               loop,
  input  logic               go,
  input  logic               step,
  input  logic               halt,
  input  logic               done,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic               color,
  output logic               start,
  output logic               busy,
  output logic               seq_done
);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, WAIT_STEP} state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] tx0 [DEPTH];
  logic [COORD_W-1:0] ty0 [DEPTH];
  logic [COORD_W-1:0] tx1 [DEPTH];
  logic [COORD_W-1:0] ty1 [DEPTH];
  logic [IDX_W-1:0]   cur_idx;
  logic [CNT_W-1:0]   n_eff;
  logic [CNT_W-1:0]   n_go;
  logic               erase_r, loop_r, halt_l;

  logic               issue, go_acc, fin, halt_nxt, last_line;
  logic [IDX_W-1:0]   issue_idx;
  logic               issue_color;

  assign busy = (state != IDLE);
  assign n_go = (num_lines > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_lines;

  // The pass ends after the draw (or the erase, when enabled) of the final entry.
  assign last_line = !(erase_r && color) && (CNT_W'(cur_idx) == n_eff - CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    go_acc      = 1'b0;
    fin         = 1'b0;
    halt_nxt    = halt_l;
    issue_color = !(erase_r && color);
    if (erase_r && color)
      issue_idx = cur_idx;
    else if (last_line)
      issue_idx = '0;
    else
      issue_idx = cur_idx + IDX_W'(1);

    case (state)
      IDLE: begin
        halt_nxt = 1'b0;
        if (go && (n_go != '0)) begin
          go_acc      = 1'b1;
          issue       = 1'b1;
          issue_idx   = '0;
          issue_color = 1'b1;
          state_nxt   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (halt)
          halt_nxt = 1'b1;
        // done in the start cycle belongs to the previous line, not this one.
        if (done && !start) begin
          if (halt_l || halt || (last_line && !loop_r)) begin
            state_nxt = IDLE;
            fin       = 1'b1;
            halt_nxt  = 1'b0;
          end else begin
            state_nxt = WAIT_STEP;
          end
        end
      end
      WAIT_STEP: begin
        if (halt) begin
          state_nxt = IDLE;
          fin       = 1'b1;
        end else if (step) begin
          issue     = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      color    <= 1'b0;
      start    <= 1'b0;
      seq_done <= 1'b0;
      halt_l   <= 1'b0;
      cur_idx  <= '0;
      n_eff    <= '0;
      erase_r  <= 1'b0;
      loop_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx0[i] <= '0;
        ty0[i] <= '0;
        tx1[i] <= '0;
        ty1[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      start    <= issue;
      seq_done <= fin;
      halt_l   <= halt_nxt;
      if (go_acc) begin
        n_eff   <= n_go;
        erase_r <= erase_en;
        loop_r  <= loop;
      end
      if (issue) begin
        cur_idx <= issue_idx;
        color   <= issue_color;
        x0      <= tx0[issue_idx];
        y0      <= ty0[issue_idx];
        x1      <= tx1[issue_idx];
        y1      <= ty1[issue_idx];
      end
      if (load_en && (state == IDLE)) begin
        tx0[load_idx] <= load_x0;
        ty0[load_idx] <= load_y0;
        tx1[load_idx] <= load_x1;
        ty1[load_idx] <= load_y1;
      end
    end
  end

endmodule

// File: doc/line_sequencer.md
LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 11, coordinate width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, segment-table entries; IDX_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
REQ-003 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- load_en  in  1  write one table entry
- load_idx  in  IDX_W  entry to write
- load_x0, load_y0, load_x1, load_y1  in  COORD_W each  segment endpoints
- num_lines  in  CNT_W  entries used per pass
- erase_en  in  1  1 = draw+erase each segment; 0 = draw only
- loop  in  1  1 = wrap after last segment; 0 = one pass
- go  in  1  start sequence
- step  in  1  pacing tick, advance to next line
- halt  in  1  stop at next step boundary
- done  in  1  downstream line drawer finished
- x0, y0, x1, y1  out  COORD_W each  current segment
- color  out  1  1 = draw, 0 = erase
- start  out  1  one-cycle request to line drawer
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle end-of-sequence pulse

Function
REQ-004 SHALL hold a DEPTH-entry table of {x0,y0,x1,y1}; load_en writes entry load_idx at the clock edge, only while busy=0; writes while busy=1 SHALL be dropped.
REQ-005 Effective count N SHALL be min(num_lines, DEPTH), sampled when go is accepted and held until return to IDLE.
REQ-006 FSM states SHALL be IDLE, WAIT_DONE, WAIT_STEP; busy = (state != IDLE).
REQ-007 IDLE: go=1 with N>=1 SHALL, at that edge, load outputs from entry 0, set color=1, pulse start, and enter WAIT_DONE; go with N=0 SHALL be ignored.
REQ-008 start SHALL be high for exactly one cycle per issued line, and outputs x0..y1/color SHALL stay constant from that cycle until the next issue.
REQ-009 WAIT_DONE: done is sampled only from the cycle after start; done=1 SHALL end the current line.
REQ-010 Line order with erase_en=1: entry0 color1, entry0 color0, entry1 color1, entry1 color0, ... entry N-1 color0; with erase_en=0: entry0..N-1 all color1.
REQ-011 On done for a line that is not last in the pass, or is last with loop=1, SHALL enter WAIT_STEP; the last line wraps to entry 0 color1.
REQ-012 On done for the last line with loop=0, SHALL enter IDLE and pulse seq_done for one cycle.
REQ-013 WAIT_STEP: step=1 SHALL issue the next line per REQ-007/008 (load, pulse start, enter WAIT_DONE).
REQ-014 WAIT_STEP: halt=1 SHALL enter IDLE and pulse seq_done; halt with step in the same cycle SHALL take priority (no start).
REQ-015 halt in WAIT_DONE SHALL be latched and acted on when entering WAIT_STEP (no new start issued).
REQ-016 go, step while not in their accepting state SHALL be ignored; erase_en and loop SHALL be sampled when go is accepted.

Reset
REQ-017 reset SHALL override all inputs and, at the edge, set state IDLE, x0=y0=x1=y1=0, color=0, start=0, busy=0, seq_done=0, halt latch=0, and all table entries to 0.
REQ-018 reset mid-sequence SHALL abort without seq_done and without further start pulses.

Verification
REQ-019 Load 3 entries (0:(320,240,80,240), 1:(320,240,160,120), 2:(320,240,240,0)), N=3, erase_en=1, loop=0, go, done 2 cycles after each start, step each WAIT_STEP -> 6 start pulses, colors 1,0,1,0,1,0, coordinates per entry, one seq_done after 6th done, busy low.
REQ-020 Same table, erase_en=0, loop=1, 7 lines -> 7th start presents entry 0 color1 (wrap), busy stays high.
REQ-021 halt and step asserted together in WAIT_STEP -> no start, IDLE next cycle, seq_done pulse 1 cycle.
REQ-022 num_lines=0 then go -> busy stays 0, no start; num_lines=12 with DEPTH=8 -> pass of 8 entries.
REQ-023 load_en to entry 1 while busy -> entry 1 unchanged in subsequent pass; done pulse coincident with start ignored.
REQ-024 reset asserted in WAIT_DONE -> next cycle all outputs 0, busy 0, no seq_done; table reads back zeros on next pass.
